// File: rtl/execute_muldiv_pkg.sv
// rtl/execute_muldiv_pkg.sv - shared encodings for the iterative M-extension unit
//
// Purpose: funct3 encodings of the RV M-extension ops, the FSM state type and
// small helpers that decode operand signedness from funct3.
package execute_muldiv_pkg;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // rs1 is treated as signed by every op except the fully unsigned ones.
  function automatic logic op_signed_a(input logic [2:0] op);
    return (op != MULDIV_MULHU) && (op != MULDIV_DIVU) && (op != MULDIV_REMU);
  endfunction

  // rs2 is signed only for MUL/MULH/DIV/REM; MULHSU treats it as unsigned.
  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == MULDIV_MUL) || (op == MULDIV_MULH) ||
           (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

endpackage

// File: rtl/execute_muldiv_iter.sv
// rtl/execute_muldiv_iter.sv - unsigned shift-add multiplier / restoring divider core
//
// Purpose: iterates on operand magnitudes only; sign handling lives in the parent.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   start_i     - load a_i/b_i and begin iterating
//   div_i       - 1: restoring divide (1 bit/cycle), 0: multiply (MUL_BITS/cycle)
//   abort_i     - drop the running operation, counter back to 0
//   a_i, b_i    - multiplier/dividend, multiplicand/divisor magnitudes
//   done_o      - high during the final iteration cycle
//   acc_o       - mul: full 2*XLEN product; div: {remainder, quotient}
module execute_muldiv_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              div_i,
  input  logic              abort_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              done_o,
  output logic [2*XLEN-1:0] acc_o
);

  localparam int ITER = XLEN / MUL_BITS;
  localparam int CW   = $clog2(XLEN);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic                run_q, run_d;
  logic                div_q, div_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;

  logic [CW-1:0]          last;
  logic [XLEN+MUL_BITS-1:0] pp, hi_sum;
  logic [2*XLEN-1:0]      mul_next, div_next;
  logic [XLEN:0]          trial;

  assign last   = div_q ? CW'(XLEN - 1) : CW'(ITER - 1);
  assign done_o = run_q && (cnt_q == last);
  assign acc_o  = acc_q;

  // Multiply: the low half holds the remaining multiplier bits; each cycle the
  // lowest MUL_BITS of it select a partial product added into the high half,
  // then the whole accumulator shifts right by MUL_BITS.
  always_comb begin
    pp       = {{MUL_BITS{1'b0}}, b_q} * {{XLEN{1'b0}}, acc_q[MUL_BITS-1:0]};
    hi_sum   = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} + pp;
    mul_next = {hi_sum, acc_q[XLEN-1:MUL_BITS]};
  end

  // Divide: {rem, quot} shifts left one bit; the divisor is subtracted from the
  // shifted remainder and the result kept only when it did not borrow.
  always_comb begin
    trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    div_next = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                           : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    div_d = div_q;
    acc_d = acc_q;
    b_d   = b_q;
    if (abort_i) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start_i) begin
      acc_d = {{XLEN{1'b0}}, a_i};
      b_d   = b_i;
      div_d = div_i;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = div_q ? div_next : mul_next;
      if (done_o) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      div_q <= div_d;
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

endmodule

// File: rtl/execute_muldiv.sv
// rtl/execute_muldiv.sv - iterative RV M-extension unit beside the EX-stage ALU
//
// Purpose: runs MUL*/DIV*/REM* over several cycles, requests a pipeline freeze
// through busy, and feeds a registered result into the EX/MEM register.
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   valid_in, exception_in         - EX slot occupancy and pending exception
//   muldiv_in, muldiv_op           - M-extension op flag and its funct3
//   rs1_data, rs2_data, rd_addr_in - operands and destination
//   stall, invalidate              - downstream hold, slot flush
//   data_hazard                    - rd of an in-flight muldiv slot, else 0
//   busy                           - freeze request to the hazard unit
//   result, rd_addr_out            - registered result and destination
//   muldiv_out, valid_out          - registered writeback-valid and slot-valid
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            exception_in,
  input  logic            muldiv_in,
  input  logic [2:0]      muldiv_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr_in,
  input  logic            stall,
  input  logic            invalidate,
  output logic [4:0]      data_hazard,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_out,
  output logic            muldiv_out,
  output logic            valid_out
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e state_q, state_d;

  logic            start, special, div_zero, sgn_ovf, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b, spec_val;

  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            sign_a_q, sign_b_q, special_q;
  logic [XLEN-1:0] spec_val_q;

  logic              iter_done;
  logic [2*XLEN-1:0] iter_acc, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, final_res;

  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;
  logic            muldiv_out_q, valid_out_q;

  assign sign_a   = op_signed_a(muldiv_op) && rs1_data[XLEN-1];
  assign sign_b   = op_signed_b(muldiv_op) && rs2_data[XLEN-1];
  assign mag_a    = sign_a ? -rs1_data : rs1_data;
  assign mag_b    = sign_b ? -rs2_data : rs2_data;
  assign div_zero = (rs2_data == '0);
  // Only the signed divide ops (funct3[0]=0) can overflow.
  assign sgn_ovf  = !muldiv_op[0] && (rs1_data == MOST_NEG) && (rs2_data == '1);
  assign special  = muldiv_op[2] && (div_zero || sgn_ovf);
  // funct3[1] separates REM* from DIV*.
  assign spec_val = div_zero ? (muldiv_op[1] ? rs1_data : '1)
                             : (muldiv_op[1] ? '0 : rs1_data);

  assign start       = valid_in && !exception_in && muldiv_in && !invalidate &&
                       (state_q == MD_IDLE);
  assign busy        = start || (state_q == MD_MUL) || (state_q == MD_DIV);
  assign data_hazard = (valid_in && !exception_in && muldiv_in) ? rd_addr_in : 5'd0;

  execute_muldiv_iter #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_iter (
    .clk     (clk),
    .reset   (reset),
    .start_i (start && !special),
    .div_i   (muldiv_op[2]),
    .abort_i (invalidate),
    .a_i     (mag_a),
    .b_i     (mag_b),
    .done_o  (iter_done),
    .acc_o   (iter_acc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (special)           state_d = MD_DONE;
          else if (muldiv_op[2]) state_d = MD_DIV;
          else                   state_d = MD_MUL;
        end
      end
      MD_MUL, MD_DIV: begin
        if (invalidate)     state_d = MD_IDLE;
        else if (iter_done) state_d = MD_DONE;
      end
      MD_DONE: begin
        // Leaving DONE only at the consuming edge keeps the held slot from
        // being accepted a second time.
        if (invalidate || !stall) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Sign fix-up of the magnitude result.
  always_comb begin
    prod_s = (sign_a_q ^ sign_b_q) ? -iter_acc : iter_acc;
    quot_s = (sign_a_q ^ sign_b_q) ? -iter_acc[XLEN-1:0] : iter_acc[XLEN-1:0];
    rem_s  = sign_a_q ? -iter_acc[2*XLEN-1:XLEN] : iter_acc[2*XLEN-1:XLEN];
    if (special_q)             final_res = spec_val_q;
    else if (op_q[2])          final_res = op_q[1] ? rem_s : quot_s;
    else if (op_q == MULDIV_MUL) final_res = prod_s[XLEN-1:0];
    else                       final_res = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MD_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      special_q  <= 1'b0;
      spec_val_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        op_q       <= muldiv_op;
        rd_q       <= rd_addr_in;
        sign_a_q   <= sign_a;
        sign_b_q   <= sign_b;
        special_q  <= special;
        spec_val_q <= spec_val;
      end
    end
  end

  // Output register: an abort clears it even under stall; otherwise stall holds it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q     <= '0;
      rd_out_q     <= '0;
      muldiv_out_q <= 1'b0;
      valid_out_q  <= 1'b0;
    end else if (invalidate && (state_q != MD_IDLE)) begin
      muldiv_out_q <= 1'b0;
      valid_out_q  <= 1'b0;
    end else if (!stall) begin
      if (state_q == MD_DONE) begin
        result_q     <= final_res;
        rd_out_q     <= rd_q;
        muldiv_out_q <= 1'b1;
        valid_out_q  <= 1'b1;
      end else begin
        // A slot that just started iterating is a bubble until DONE.
        muldiv_out_q <= 1'b0;
        valid_out_q  <= (state_q == MD_IDLE) && valid_in && !invalidate && !start;
      end
    end
  end

  assign result      = result_q;
  assign rd_addr_out = rd_out_q;
  assign muldiv_out  = muldiv_out_q;
  assign valid_out   = valid_out_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// tb/tb_execute_muldiv.sv - self-checking bench for execute_muldiv
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, exception_in, muldiv_in, stall, invalidate;
  logic [2:0]  muldiv_op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr_in;
  logic [4:0]  data_hazard;
  logic        busy;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;
  logic        muldiv_out, valid_out;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  execute_muldiv #(.XLEN(32), .MUL_BITS(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .exception_in (exception_in),
    .muldiv_in    (muldiv_in),
    .muldiv_op    (muldiv_op),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .rd_addr_in   (rd_addr_in),
    .stall        (stall),
    .invalidate   (invalidate),
    .data_hazard  (data_hazard),
    .busy         (busy),
    .result       (result),
    .rd_addr_out  (rd_addr_out),
    .muldiv_out   (muldiv_out),
    .valid_out    (valid_out)
  );

  // Architectural result of an M-extension op, from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    int          ia, ib;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = int'(a);
    ib = int'(b);
    r  = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = 32'(ia / ib);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = 32'(ia % ib);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_busy(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
    if (!op[2]) return 17;
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the consuming edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int stall_cycles,
                        input logic [31:0] exp_res, input int exp_busy);
    int n;
    valid_in = 1'b1; muldiv_in = 1'b1; exception_in = 1'b0;
    muldiv_op = op; rs1_data = a; rs2_data = b; rd_addr_in = rd;
    #1;
    chk("data_hazard", 64'(data_hazard), 64'(rd));
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(n), 64'(exp_busy));
    stall = (stall_cycles > 0);
    for (int i = 0; i < stall_cycles; i++) begin
      @(posedge clk); #1;
      chk("stalled_busy", 64'(busy), 64'(0));
      chk("stalled_muldiv_out", 64'(muldiv_out), 64'(0));
      if (i == stall_cycles - 1) stall = 1'b0;
    end
    @(posedge clk); #1;
    valid_in = 1'b0; muldiv_in = 1'b0;
    #1;
    chk("result", 64'(result), 64'(exp_res));
    chk("muldiv_out", 64'(muldiv_out), 64'(1));
    chk("valid_out", 64'(valid_out), 64'(1));
    chk("rd_addr_out", 64'(rd_addr_out), 64'(rd));
    chk("busy_after", 64'(busy), 64'(0));
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b1; valid_in = 1'b0; exception_in = 1'b0; muldiv_in = 1'b0;
    muldiv_op = 3'd0; rs1_data = '0; rs2_data = '0; rd_addr_in = '0;
    stall = 1'b0; invalidate = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_rd", 64'(rd_addr_out), 64'(0));
    chk("rst_muldiv_out", 64'(muldiv_out), 64'(0));
    chk("rst_valid_out", 64'(valid_out), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 5'd1, 0, 32'hFFFF_FFFF, 17);
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd2, 0, 32'hFFFF_FFFD, 33);
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd3, 0, 32'hFFFF_FFFF, 33);
    run_op(3'd5, 32'h0000_0005, 32'h0000_0000, 5'd4, 0, 32'hFFFF_FFFF, 1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0, 32'h0000_0000, 1);
    run_op(3'd0, 32'd7, 32'd6, 5'd6, 3, 32'd42, 17);

    // Invalidate mid-divide while the output register is stalled.
    stall = 1'b1; valid_in = 1'b1; muldiv_in = 1'b1;
    muldiv_op = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd7; rd_addr_in = 5'd7;
    repeat (5) @(posedge clk);
    #1;
    chk("inv_busy_before", 64'(busy), 64'(1));
    chk("inv_held_muldiv_out", 64'(muldiv_out), 64'(1));
    invalidate = 1'b1;
    @(posedge clk); #1;
    invalidate = 1'b0; valid_in = 1'b0; muldiv_in = 1'b0; stall = 1'b0;
    #1;
    chk("inv_busy", 64'(busy), 64'(0));
    chk("inv_muldiv_out", 64'(muldiv_out), 64'(0));
    chk("inv_valid_out", 64'(valid_out), 64'(0));
    @(posedge clk); #1;
    chk("inv_busy_next", 64'(busy), 64'(0));
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0, 32'hFFFF_FFFE, 17);

    // Reset in the middle of a multiply.
    stall = 1'b1; valid_in = 1'b1; muldiv_in = 1'b1;
    muldiv_op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd5; rd_addr_in = 5'd9;
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid_busy_before", 64'(busy), 64'(1));
    reset = 1'b1; valid_in = 1'b0; muldiv_in = 1'b0;
    #1;
    chk("rstmid_result", 64'(result), 64'(0));
    chk("rstmid_rd", 64'(rd_addr_out), 64'(0));
    chk("rstmid_muldiv_out", 64'(muldiv_out), 64'(0));
    chk("rstmid_valid_out", 64'(valid_out), 64'(0));
    chk("rstmid_busy", 64'(busy), 64'(0));
    stall = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_idle", 64'(busy), 64'(0));

    // Slot that already carries an exception never starts.
    valid_in = 1'b1; exception_in = 1'b1; muldiv_in = 1'b1;
    muldiv_op = 3'd4; rs1_data = 32'd9; rs2_data = 32'd3; rd_addr_in = 5'd10;
    #1;
    chk("exc_busy", 64'(busy), 64'(0));
    chk("exc_hazard", 64'(data_hazard), 64'(0));
    @(posedge clk); #1;
    chk("exc_valid_out", 64'(valid_out), 64'(1));
    chk("exc_muldiv_out", 64'(muldiv_out), 64'(0));
    chk("exc_busy_next", 64'(busy), 64'(0));
    valid_in = 1'b0; exception_in = 1'b0; muldiv_in = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 14; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rop, ra, rb, 5'($urandom_range(1, 31)), int'($urandom_range(0, 2)),
             ref_model(rop, ra, rb), ref_busy(rop, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
